// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and constants for the APB command master
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int STRB_WIDTH     = DATA_WIDTH_DEF / 8;

    // Low address bits that must be zero for a word-aligned transfer
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command, response and APB bus signals of the APB command master
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [SW-1:0]         cmd_strb_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    logic                  psel_o;
    logic                  penable_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [SW-1:0]         pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - clearable saturating ACCESS-cycle counter with done flag
module apb_timeout_cnt #(
    parameter int MAX_COUNT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);
    localparam int                CW   = $clog2(MAX_COUNT) + 1;
    localparam logic [CW-1:0]     LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count parks at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB4 requester turning a command stream into single transfers; optional APB_TIMEOUT_EN
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    apb_cmd_master_if.master bus
);
    apb_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  aligned;
    logic                  timeout_done;

    assign aligned = ((bus.cmd_addr_i[1:0] & ALIGN_MASK) == 2'b00);

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (pclk_i),
        .rst_i  (prst_i),
        .clr_i  (state_q == SETUP),
        .inc_i  ((state_q == ACCESS) && !bus.pready_i),
        .done_o (timeout_done)
    );
`else
    assign timeout_done = 1'b0;
`endif

    // Next-state and next-output logic; the APB output registers double as the command latch
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    cmd_ready_d = 1'b0;
                    if (aligned) begin
                        state_d  = SETUP;
                        psel_d   = 1'b1;
                        paddr_d  = bus.cmd_addr_i;
                        pwrite_d = bus.cmd_write_i;
                        pwdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                        pstrb_d  = bus.cmd_write_i ? bus.cmd_strb_i  : '0;
                    end else begin
                        // Misaligned: answer with an error, never touch the bus
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready_i || timeout_done) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
                    rsp_valid_d = 1'b1;
                    if (bus.pready_i) begin
                        rsp_err_d   = bus.pslverr_i;
                        rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus and discards any response
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.pstrb_o     = pstrb_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with a wait-state APB slave model
module tb_apb_cmd_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_cmd_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk_i (clk),
        .prst_i (rst),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    logic [31:0] smem [0:1023];
    int unsigned cfg_waits = 0;
    logic        cfg_err   = 1'b0;
    logic        cfg_stall = 1'b0;
    logic [2:0]  wait_left = '0;

    always @(posedge clk) begin
        if (bus.psel_o && !bus.penable_o)
            wait_left <= 3'(cfg_waits);
        else if (bus.psel_o && bus.penable_o && wait_left != 0)
            wait_left <= wait_left - 3'd1;
        if (bus.psel_o && bus.penable_o && bus.pready_i && bus.pwrite_o && !cfg_err)
            for (int b = 0; b < 4; b++)
                if (bus.pstrb_o[b]) smem[bus.paddr_o[11:2]][8*b +: 8] <= bus.pwdata_o[8*b +: 8];
    end

    assign bus.pready_i  = bus.psel_o && bus.penable_o && (wait_left == 0) && !cfg_stall;
    assign bus.prdata_i  = (bus.psel_o && !bus.pwrite_o) ? smem[bus.paddr_o[11:2]] : 32'hA5A5_5A5A;
    assign bus.pslverr_i = cfg_err;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hs;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] rd_model(input logic [11:0] addr);
        int idx = int'(addr[11:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    // Response monitor: first cycle checks value and latency, later cycles check the hold
    always @(negedge clk) begin
        if (rst) begin
            have_cur = 1'b0;
        end else if (bus.rsp_valid_o) begin
            if (!have_cur) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check_eq("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(cur.rdata));
                    check_eq("rsp_err", 64'(bus.rsp_err_o), 64'(cur.err));
                    check_eq("rsp_latency", 64'(cyc - cur.hs), 64'(cur.lat));
                end
            end else begin
                check_eq("rsp_hold_rdata", 64'(bus.rsp_rdata_o), 64'(cur.rdata));
                check_eq("rsp_hold_err", 64'(bus.rsp_err_o), 64'(cur.err));
            end
            if (have_cur) begin
                check_eq("cmd_ready_in_resp", 64'(bus.cmd_ready_o), 64'(0));
                check_eq("psel_in_resp", 64'(bus.psel_o), 64'(0));
            end
            if (bus.rsp_ready_i) have_cur = 1'b0;
        end
    end

    // Bus monitor: records the last transfer and checks phase order, stability and idle zeros
    int          psel_cnt = 0;
    int          acc_cur = 0;
    int          acc_len = 0;
    logic        stable = 1'b1;
    logic        prev_setup = 1'b0;
    logic [11:0] last_paddr = '0;
    logic        last_pwrite = 1'b0;
    logic [31:0] last_pwdata = '0;
    logic [3:0]  last_pstrb = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_setup)
                check_eq("access_after_setup", 64'({bus.psel_o, bus.penable_o}), 64'(2'b11));
            if (bus.psel_o && !bus.penable_o) begin
                psel_cnt++;
                acc_cur     = 0;
                stable      = 1'b1;
                last_paddr  = bus.paddr_o;
                last_pwrite = bus.pwrite_o;
                last_pwdata = bus.pwdata_o;
                last_pstrb  = bus.pstrb_o;
            end else if (bus.psel_o && bus.penable_o) begin
                acc_cur++;
                acc_len = acc_cur;
                if (bus.paddr_o != last_paddr || bus.pwrite_o != last_pwrite ||
                    bus.pwdata_o != last_pwdata || bus.pstrb_o != last_pstrb)
                    stable = 1'b0;
            end else begin
                check_eq("idle_bus_zero",
                         64'({bus.penable_o, bus.pwrite_o, bus.pstrb_o, bus.paddr_o, bus.pwdata_o}), 64'(0));
            end
            prev_setup = bus.psel_o && !bus.penable_o;
        end else begin
            prev_setup = 1'b0;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                            input int lat, output int hs);
        exp_t e;
        int   n = 0;
        hs = -1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wd;
        bus.cmd_strb_i  = st;
        bus.cmd_valid_i = 1'b1;
        while (hs < 0 && n < 50) begin
            @(negedge clk);
            if (bus.cmd_ready_o) hs = cyc;
            n++;
        end
        if (hs < 0) begin
            check_eq("handshake_timeout", 64'(0), 64'(1));
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.hs    = hs;
            e.lat   = lat;
            sb.push_back(e);
            if (wr && !exp_err && addr[1:0] == 2'b00) begin
                logic [31:0] m = rd_model(addr);
                for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = wd[8*b +: 8];
                ref_mem[int'(addr[11:2])] = m;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 300 && !(sb.size() == 0 && !have_cur && bus.cmd_ready_o && !bus.rsp_valid_o)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    int hs, hs_prev, psel_before, n;
    logic        wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 1024; i++) smem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
        check_eq("reset_outputs_zero",
                 64'({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o, bus.rsp_err_o, bus.paddr_o}), 64'(0));
        check_eq("reset_data_zero", 64'({bus.rsp_rdata_o, bus.pwdata_o}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait write
        send_cmd(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3, hs);
        wait_drain();
        check_eq("wr_paddr", 64'(last_paddr), 64'(12'h010));
        check_eq("wr_pwrite", 64'(last_pwrite), 64'(1));
        check_eq("wr_pwdata", 64'(last_pwdata), 64'(32'hDEAD_BEEF));
        check_eq("wr_pstrb", 64'(last_pstrb), 64'(4'hF));
        check_eq("wr_access_len", 64'(acc_len), 64'(1));

        // Read with two wait states
        cfg_waits = 2;
        send_cmd(1'b0, 12'h010, 32'h1111_2222, 4'hF, rd_model(12'h010), 1'b0, 5, hs);
        wait_drain();
        cfg_waits = 0;
        check_eq("rd_access_len", 64'(acc_len), 64'(3));
        check_eq("rd_bus_stable", 64'(stable), 64'(1));
        check_eq("rd_pwrite", 64'(last_pwrite), 64'(0));
        check_eq("rd_pstrb_zero", 64'(last_pstrb), 64'(0));
        check_eq("rd_pwdata_zero", 64'(last_pwdata), 64'(0));

        // Misaligned read never reaches the bus
        psel_before = psel_cnt;
        send_cmd(1'b0, 12'h013, 32'h0, 4'h0, 32'h0, 1'b1, 1, hs);
        wait_drain();
        check_eq("misaligned_no_psel", 64'(psel_cnt), 64'(psel_before));

        // Slave error with response back-pressure
        cfg_err = 1'b1;
        bus.rsp_ready_i = 1'b0;
        send_cmd(1'b1, 12'h020, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 3, hs);
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("slverr_rsp_seen", 64'(bus.rsp_valid_o), 64'(1));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b1;
        wait_drain();
        cfg_err = 1'b0;

        // Back-to-back random traffic, one transfer per four cycles
        hs_prev = -1;
        for (int i = 0; i < 8; i++) begin
            wr = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            a  = 12'h040 + 12'(4 * $urandom_range(0, 3));
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            send_cmd(wr, a, d, s, wr ? 32'h0 : rd_model(a), 1'b0, 3, hs);
            if (hs_prev >= 0) check_eq("throughput_gap", 64'(hs - hs_prev), 64'(4));
            hs_prev = hs;
        end
        wait_drain();

        // Reset pulse during ACCESS discards the transfer
        cfg_waits = 4;
        send_cmd(1'b0, 12'h010, 32'h0, 4'h0, rd_model(12'h010), 1'b0, 7, hs);
        n = 0;
        while (!bus.penable_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_reached_access", 64'(bus.penable_o), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_bus_dropped", 64'({bus.psel_o, bus.penable_o}), 64'(0));
        check_eq("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
        for (int i = 0; i < 6; i++) begin
            check_eq("rst_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
            @(negedge clk);
        end
        cfg_waits = 0;
        @(posedge clk);
        #1;

`ifdef APB_TIMEOUT_EN
        // Stalled slave: abort after exactly four ACCESS cycles, then recover
        cfg_stall = 1'b1;
        send_cmd(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 1'b1, 6, hs);
        wait_drain();
        cfg_stall = 1'b0;
        check_eq("timeout_access_len", 64'(acc_len), 64'(4));
        send_cmd(1'b0, 12'h010, 32'h0, 4'h0, rd_model(12'h010), 1'b0, 3, hs);
        wait_drain();
`endif

        // Read back the first write after all of the above
        send_cmd(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, hs);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Synthesizable APB4 requester (initiator).
- Converts a valid/ready command stream into single APB transfers toward slaves such as the APB SRAM wrapper.
- Returns one response per command on a valid/ready response channel.
- Replaces the behavioural bus model wherever a real bus master is needed in the design.

Parameters:
- ADDR_WIDTH, 12, byte address width (10 word bits + 2 byte bits).
- DATA_WIDTH, 32, data bus width; fixed at 32 in this version.
- TIMEOUT_CYCLES, 256, maximum number of ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk_i  in  1  clock
- prst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  byte address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_strb_i  in  DATA_WIDTH/8  write byte strobes
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- rsp_err_o  out  1  slave error, misalignment or timeout
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_WIDTH  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- pstrb_o  out  DATA_WIDTH/8  APB strobes
- pready_i  in  1  slave ready
- prdata_i  in  DATA_WIDTH  slave read data
- pslverr_i  in  1  slave error

Behaviour:
- Reset: state IDLE; every output is 0 except cmd_ready_o, which is 1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready_o = (state == IDLE). A handshake latches write, addr, wdata and strb.
- IDLE -> SETUP on handshake with an aligned address (cmd_addr_i[1:0] == 0).
- IDLE -> RESP on handshake with a misaligned address:
  - no APB transfer is issued;
  - rsp_err_o = 1, rsp_rdata_o = 0.
- SETUP (exactly 1 cycle): psel=1, penable=0. paddr, pwrite, pwdata and pstrb are driven from latched values.
- ACCESS: psel=1, penable=1. All APB outputs are held stable until pready_i = 1.
- On pready_i = 1 in ACCESS:
  - capture prdata_i (reads only; writes capture 0) and pslverr_i;
  - go to RESP.
- Reads drive pstrb_o = 0 and pwdata_o = 0.
- Outside SETUP/ACCESS: psel=0, penable=0, and paddr/pwdata/pstrb/pwrite are held at 0.
- RESP: rsp_valid_o = 1. Data and err are held until rsp_ready_i; then go to IDLE. Back-pressure may last indefinitely.
- Latency with a zero-wait slave:
  - handshake at cycle N;
  - SETUP at N+1;
  - ACCESS at N+2;
  - rsp_valid at N+3.
- Peak throughput: one transfer per 4 cycles when rsp_ready_i is held at 1.
- Each wait state adds 1 cycle.
- pslverr_i is sampled only when psel & penable & pready_i. prdata_i is ignored on write transfers.
- Reset asserted mid-transfer: at the next edge psel/penable drop to 0, any pending response is discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - a counter clears on SETUP entry and increments each ACCESS cycle with pready_i = 0;
  - when it reaches TIMEOUT_CYCLES - 1 with pready_i still 0, the next cycle drops psel/penable and enters RESP with rsp_err_o = 1 and rsp_rdata_o = 0;
  - pready_i = 1 on the last allowed cycle completes the transfer normally.
- Without the macro: no counter is present and ACCESS waits indefinitely.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the ADDR_WIDTH/DATA_WIDTH defaults;
  - the STRB_WIDTH localparam;
  - the alignment-mask constant.
- One sub-module, apb_timeout_cnt: a clearable saturating counter with a done flag, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write: addr 0x010, data 0xDEADBEEF, strb 0xF, zero-wait slave.
  - SETUP then ACCESS on consecutive cycles; pwrite=1.
  - rsp_valid at handshake+3, err=0, rdata=0.
- Read: addr 0x010 after the write, slave inserting 2 wait states.
  - penable held for 3 cycles with stable paddr; pstrb=0.
  - rsp_rdata=0xDEADBEEF at handshake+5.
- Misaligned read: addr 0x013.
  - psel never asserts; rsp_valid at handshake+1 with err=1.
- Slave error: pslverr=1 with pready → rsp_err=1.
  - rsp_ready held at 0 for 5 cycles: response is held stable and cmd_ready stays 0 throughout.
- Reset pulse during ACCESS → psel/penable=0 at the next edge; cmd_ready=1; no rsp_valid.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and pready tied at 0 → rsp_err=1 after exactly 4 ACCESS cycles, then IDLE.
